neuron_argmax_collector: RTL and testbench

- Downstream stage of the single tanh neuron.
- Watches the neuron's busy/output_value pair and captures one result each time a neuron evaluation completes.
- Keeps a running signed maximum and its index over NUM_CLASSES consecutive results, then presents the winning class index to the control logic.
- Used as the classification tail of the output layer.

---
 rtl/neuron_argmax_collector.sv | 103 ++++++++++
 tb/tb_neuron_argmax_collector.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_argmax_collector.sv
// Classification tail of the output layer: captures one neuron result per busy fall and
// tracks the signed maximum and its arrival index over NUM_CLASSES results.
module neuron_argmax_collector #(
    parameter int NUM_CLASSES = 4,
    parameter int DATA_W      = 20,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              src_busy,
    input  logic [DATA_W-1:0] src_value,
    input  logic              result_ack,
    output logic              result_valid,
    output logic [IDX_W-1:0]  result_index,
    output logic [DATA_W-1:0] max_value,
    output logic [IDX_W-1:0]  sample_count,
    output logic              dropped
);

    typedef enum logic {
        COLLECT,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t            state, state_next;
    logic              busy_q;
    logic              strobe;
    logic [IDX_W-1:0]  index_next;
    logic [DATA_W-1:0] max_next;
    logic [IDX_W-1:0]  count_next;
    logic              dropped_next;

    // The neuron drops busy on the same edge it updates its output, so the value is
    // already stable during the strobe cycle.
    assign strobe       = busy_q & ~src_busy;
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= COLLECT;
            busy_q       <= 1'b0;
            result_index <= '0;
            max_value    <= '0;
            sample_count <= '0;
            dropped      <= 1'b0;
        end else begin
            state        <= state_next;
            busy_q       <= src_busy;
            result_index <= index_next;
            max_value    <= max_next;
            sample_count <= count_next;
            dropped      <= dropped_next;
        end
    end

    always_comb begin
        state_next   = state;
        index_next   = result_index;
        max_next     = max_value;
        count_next   = sample_count;
        dropped_next = dropped;

        // clear outranks everything; a coincident strobe is lost rather than deferred
        if (clear) begin
            state_next   = COLLECT;
            count_next   = '0;
            dropped_next = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (strobe) begin
                        // strict greater-than so ties keep the earlier index
                        if (sample_count == '0 ||
                            $signed(src_value) > $signed(max_value)) begin
                            max_next   = src_value;
                            index_next = sample_count;
                        end
                        count_next = sample_count + 1'b1;
                        if (sample_count == LAST_IDX) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (strobe) begin
                        dropped_next = 1'b1;
                    end
                    if (result_ack) begin
                        state_next = COLLECT;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_argmax_collector.sv
// Randomized scoreboard bench for neuron_argmax_collector, checked against a list-based
// argmax reference model.
module tb_neuron_argmax_collector;

    localparam int NUM_CLASSES = 4;
    localparam int DATA_W      = 20;
    localparam int IDX_W       = 8;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] mx;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic              src_busy = 1'b0;
    logic [DATA_W-1:0] src_value = '0;
    logic              result_ack = 1'b0;
    logic              result_valid;
    logic [IDX_W-1:0]  result_index;
    logic [DATA_W-1:0] max_value;
    logic [IDX_W-1:0]  sample_count;
    logic              dropped;

    int compareCount = 0;
    int mismatchCount = 0;

    logic signed [DATA_W-1:0] vals[$];
    exp_t                     expQ[$];
    bit                       modelDone = 1'b0;
    bit                       modelDropped = 1'b0;
    int                       modelIdx = 0;
    logic [DATA_W-1:0]        modelMax = '0;
    bit                       prevValid = 1'b0;

    neuron_argmax_collector #(
        .NUM_CLASSES(NUM_CLASSES),
        .DATA_W(DATA_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .src_busy(src_busy),
        .src_value(src_value),
        .result_ack(result_ack),
        .result_valid(result_valid),
        .result_index(result_index),
        .max_value(max_value),
        .sample_count(sample_count),
        .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/valid"}, 32'(result_valid), 32'(modelDone));
        checkOutput({tag, "/count"}, 32'(sample_count), 32'(vals.size()));
        checkOutput({tag, "/index"}, 32'(result_index), 32'(modelIdx));
        checkOutput({tag, "/max"}, 32'(max_value), 32'(modelMax));
        checkOutput({tag, "/dropped"}, 32'(dropped), 32'(modelDropped));
    endtask

    // Reference: argmax over the list of results collected so far, first index wins ties.
    task automatic modelStrobe(input logic [DATA_W-1:0] v, input bit ack);
        int best;
        if (modelDone) begin
            modelDropped = 1'b1;
            if (ack) begin
                modelDone = 1'b0;
                vals.delete();
            end
        end else begin
            vals.push_back(v);
            best = 0;
            for (int i = 1; i < vals.size(); i++) begin
                if (vals[i] > vals[best]) best = i;
            end
            modelIdx = best;
            modelMax = vals[best];
            if (vals.size() == NUM_CLASSES) begin
                modelDone = 1'b1;
                expQ.push_back('{idx: modelIdx, mx: modelMax});
            end
        end
    endtask

    task automatic modelClear();
        vals.delete();
        modelDone = 1'b0;
        modelDropped = 1'b0;
    endtask

    task automatic modelReset();
        modelClear();
        modelIdx = 0;
        modelMax = '0;
    endtask

    function automatic logic [DATA_W-1:0] randVal();
        logic [DATA_W-1:0] r;
        case ($urandom_range(0, 5))
            0: r = 20'h80000;
            1: r = 20'h7FFFF;
            2: r = 20'h30000;
            3: r = 20'h00000;
            default: r = DATA_W'($urandom);
        endcase
        return r;
    endfunction

    // One neuron evaluation: busy for a while, then busy falls with the new value.
    task automatic applyStimulus(input logic [DATA_W-1:0] v, input bit ack, input bit clr);
        src_busy = 1'b1;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        src_busy = 1'b0;
        src_value = v;
        result_ack = ack;
        clear = clr;
        if (clr) modelClear();
        else modelStrobe(v, ack);
        @(negedge clk);
        result_ack = 1'b0;
        clear = 1'b0;
        src_value = DATA_W'($urandom);
        checkAll("strobe");
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic pulseAck();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        if (modelDone) begin
            modelDone = 1'b0;
            vals.delete();
        end
        checkAll("ack");
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        modelClear();
        checkAll("clear");
    endtask

    task automatic applyReset();
        src_busy = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 modelReset();
        checkAll("async_reset");
        @(negedge clk);
        reset = 1'b1;
        src_busy = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a classification result appears.
    always @(negedge clk) begin
        exp_t e;
        if (result_valid && !prevValid) begin
            if (expQ.size() == 0) begin
                compareCount++;
                mismatchCount++;
                $display("[TB] FAIL unexpected_result: got index %0d, expected no result", result_index);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_index", 32'(result_index), 32'(e.idx));
                checkOutput("sb_max", 32'(max_value), 32'(e.mx));
                checkOutput("sb_count", 32'(sample_count), 32'(NUM_CLASSES));
            end
        end
        prevValid = result_valid;
    end

    initial begin
        logic [DATA_W-1:0] tp1[4] = '{20'h04000, 20'h20000, 20'hF0000, 20'h10000};
        logic [DATA_W-1:0] tp2[4] = '{20'h30000, 20'h30000, 20'h00000, 20'h30000};
        logic [DATA_W-1:0] tp3[4] = '{20'hC0000, 20'h80000, 20'hE0000, 20'hFFFFF};
        logic [DATA_W-1:0] tp5[4] = '{20'h01000, 20'h02000, 20'h03000, 20'h00000};

        repeat (2) @(negedge clk);
        modelReset();
        checkAll("reset");
        reset = 1'b1;
        @(negedge clk);

        foreach (tp1[i]) applyStimulus(tp1[i], 1'b0, 1'b0);
        checkOutput("tp1_valid", 32'(result_valid), 32'd1);
        checkOutput("tp1_index", 32'(result_index), 32'd1);
        checkOutput("tp1_max", 32'(max_value), 32'h20000);
        checkOutput("tp1_count", 32'(sample_count), 32'd4);
        pulseAck();

        foreach (tp2[i]) applyStimulus(tp2[i], 1'b0, 1'b0);
        checkOutput("tp2_index", 32'(result_index), 32'd0);
        checkOutput("tp2_max", 32'(max_value), 32'h30000);
        pulseAck();

        foreach (tp3[i]) applyStimulus(tp3[i], 1'b0, 1'b0);
        checkOutput("tp3_index", 32'(result_index), 32'd3);
        checkOutput("tp3_max", 32'(max_value), 32'hFFFFF);

        applyStimulus(20'h7FFFF, 1'b0, 1'b0);
        checkOutput("tp4_dropped", 32'(dropped), 32'd1);
        checkOutput("tp4_hold_index", 32'(result_index), 32'd3);
        pulseAck();
        checkOutput("tp4_ack_count", 32'(sample_count), 32'd0);
        foreach (tp1[i]) applyStimulus(tp1[i], 1'b0, 1'b0);
        checkOutput("tp4_sticky", 32'(dropped), 32'd1);
        pulseAck();

        applyStimulus(20'h40000, 1'b0, 1'b0);
        applyStimulus(20'h50000, 1'b0, 1'b0);
        applyStimulus(20'h60000, 1'b0, 1'b1);
        foreach (tp5[i]) applyStimulus(tp5[i], 1'b0, 1'b0);
        checkOutput("tp5_index", 32'(result_index), 32'd2);
        checkOutput("tp5_max", 32'(max_value), 32'h03000);
        checkOutput("tp5_dropped", 32'(dropped), 32'd0);
        pulseAck();

        applyStimulus(20'h11111, 1'b0, 1'b0);
        applyStimulus(20'h22222, 1'b0, 1'b0);
        applyReset();
        applyStimulus(20'h05000, 1'b0, 1'b0);
        checkOutput("tp6_count", 32'(sample_count), 32'd1);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 19))
                0: pulseClear();
                1: applyStimulus(randVal(), 1'b1, 1'b0);
                2: applyStimulus(randVal(), 1'b0, 1'b1);
                3: applyReset();
                4, 5, 6: pulseAck();
                default: applyStimulus(randVal(), 1'b0, 1'b0);
            endcase
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
